// File: rtl/axis_tag_extractor_pkg.sv
// Shared definitions for the tag extractor and its skid stage: default tag
// bit position (shared with the upstream tagger) and skid-state encodings.
package axis_tag_extractor_pkg;

  localparam int TAG_BIT_DEFAULT = 208;

  localparam logic [1:0] SKID_EMPTY = 2'd0;
  localparam logic [1:0] SKID_ONE   = 2'd1;
  localparam logic [1:0] SKID_FULL  = 2'd2;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry registered AXI4-Stream skid stage: one-cycle latency, one beat
// per cycle sustained, slave ready registered.
//
// Handshake: a beat moves on either side only in a cycle where valid and
// ready are both high at the rising edge. valid never depends on ready,
// and a presented beat stays stable until it is taken.
//
// The FSM state is held in 'state' (SKID_EMPTY / SKID_ONE / SKID_FULL) so
// it can be observed directly.
module axis_skid_buffer
  import axis_tag_extractor_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 256
) (
  input  logic                        aclk,
  input  logic                        areset,
  output logic                        s_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_tdata,
  input  logic                        s_tvalid,
  input  logic                        m_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_tdata,
  output logic                        m_tvalid
);

  logic [1:0]                  state;
  logic [1:0]                  state_next;
  logic [AXIS_TDATA_WIDTH-1:0] out_data;
  logic [AXIS_TDATA_WIDTH-1:0] skid_data;
  logic                        ready_q;
  logic                        accept;
  logic                        deliver;

  assign accept   = s_tvalid & ready_q;
  assign deliver  = (state != SKID_EMPTY) & m_tready;
  assign s_tready = ready_q;
  assign m_tvalid = (state != SKID_EMPTY);
  assign m_tdata  = out_data;

  // Next-state logic for the occupancy FSM.
  always_comb begin
    state_next = state;
    case (state)
      SKID_EMPTY: if (accept) state_next = SKID_ONE;
      SKID_ONE: begin
        if (accept && !deliver)      state_next = SKID_FULL;
        else if (!accept && deliver) state_next = SKID_EMPTY;
        else                         state_next = SKID_ONE;
      end
      SKID_FULL:  if (deliver) state_next = SKID_ONE;
      default:    state_next = SKID_EMPTY;
    endcase
  end

  // State, registered ready and the two data slots.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= SKID_EMPTY;
      ready_q   <= 1'b0;
      out_data  <= '0;
      skid_data <= '0;
    end else begin
      state   <= state_next;
      // Ready drops only while the skid slot holds a beat.
      ready_q <= (state_next != SKID_FULL);
      case (state)
        SKID_EMPTY: if (accept) out_data <= s_tdata;
        SKID_ONE: begin
          if (accept && deliver) out_data  <= s_tdata;
          else if (accept)       skid_data <= s_tdata;
        end
        SKID_FULL:  if (deliver) out_data <= skid_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/axis_tag_extractor.sv
// Tag extractor: watches the embedded flag at TAG_BIT on accepted beats,
// reports rising-edge tag events (pulse, sample index, running count) and
// forwards the stream through a two-entry skid stage.
//
// Build option: define AXIS_TAG_EXTRACTOR_STRIP_EN to clear the flag bit in
// the forwarded data; otherwise data passes bit-exact.
module axis_tag_extractor
  import axis_tag_extractor_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 256,
  parameter int TAG_BIT          = TAG_BIT_DEFAULT,
  parameter int CNTR_WIDTH       = 32
) (
  input  logic                        aclk,
  input  logic                        areset,
  output logic                        s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        tag_pulse,
  output logic [CNTR_WIDTH-1:0]       tag_position,
  output logic [CNTR_WIDTH-1:0]       tag_count
);

  logic                        flag;
  logic                        accept;
  logic                        tag_event;
  logic                        prev_flag;
  logic [CNTR_WIDTH-1:0]       sample_cnt;
  logic [AXIS_TDATA_WIDTH-1:0] fwd_data;

  assign flag      = s_axis_tdata[TAG_BIT];
  assign accept    = s_axis_tvalid & s_axis_tready;
  assign tag_event = accept & flag & ~prev_flag;

  // Forwarded data, optionally with the flag bit cleared.
  always_comb begin
    fwd_data = s_axis_tdata;
`ifdef AXIS_TAG_EXTRACTOR_STRIP_EN
    fwd_data[TAG_BIT] = 1'b0;
`endif
  end

  // Sample counter, flag history and event reporting.
  always_ff @(posedge aclk) begin
    if (areset) begin
      sample_cnt   <= '0;
      prev_flag    <= 1'b0;
      tag_pulse    <= 1'b0;
      tag_position <= '0;
      tag_count    <= '0;
    end else begin
      tag_pulse <= tag_event;
      if (accept) begin
        sample_cnt <= sample_cnt + CNTR_WIDTH'(1);
        prev_flag  <= flag;
      end
      if (tag_event) begin
        tag_position <= sample_cnt;
        tag_count    <= tag_count + CNTR_WIDTH'(1);
      end
    end
  end

  axis_skid_buffer #(
    .AXIS_TDATA_WIDTH(AXIS_TDATA_WIDTH)
  ) u_skid (
    .aclk    (aclk),
    .areset  (areset),
    .s_tready(s_axis_tready),
    .s_tdata (fwd_data),
    .s_tvalid(s_axis_tvalid),
    .m_tready(m_axis_tready),
    .m_tdata (m_axis_tdata),
    .m_tvalid(m_axis_tvalid)
  );

endmodule

// File: tb/tb_axis_tag_extractor.sv
// Bench for axis_tag_extractor: a 32-bit-counter instance and a 4-bit-counter
// instance share one stream; a negedge monitor compares both against a
// behavioural model (beat queue + event counters).
module tb_axis_tag_extractor;

  localparam int W  = 256;
  localparam int TB = 208;

  // ---------------- clock / reset ----------------
  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic          areset = 1'b1;
  logic          s_axis_tvalid = 1'b0;
  logic [W-1:0]  s_axis_tdata = '0;
  logic          m_axis_tready = 1'b1;

  logic          s_axis_tready, m_axis_tvalid, tag_pulse;
  logic [W-1:0]  m_axis_tdata;
  logic [31:0]   tag_position, tag_count;

  logic          s_tready4, m_tvalid4, tag_pulse4;
  logic [W-1:0]  m_tdata4;
  logic [3:0]    tag_position4, tag_count4;

  axis_tag_extractor #(.AXIS_TDATA_WIDTH(W), .TAG_BIT(TB), .CNTR_WIDTH(32)) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .tag_pulse(tag_pulse), .tag_position(tag_position), .tag_count(tag_count)
  );

  axis_tag_extractor #(.AXIS_TDATA_WIDTH(W), .TAG_BIT(TB), .CNTR_WIDTH(4)) dut_w4 (
    .aclk(aclk), .areset(areset),
    .s_axis_tready(s_tready4), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tdata(m_tdata4), .m_axis_tvalid(m_tvalid4),
    .tag_pulse(tag_pulse4), .tag_position(tag_position4), .tag_count(tag_count4)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  function automatic void check(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  function automatic logic [W-1:0] exp_out(logic [W-1:0] d);
    logic [W-1:0] r;
    r = d;
`ifdef AXIS_TAG_EXTRACTOR_STRIP_EN
    r[TB] = 1'b0;
`endif
    return r;
  endfunction

  function automatic logic [W-1:0] rand_data(bit flag);
    logic [W-1:0] d;
    for (int i = 0; i < W / 32; i++) d[i*32 +: 32] = $urandom();
    d[TB] = flag;
    return d;
  endfunction

  // ---------------- reference model / scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int unsigned  m_cnt = 0, m_pos = 0, m_count = 0;
  bit           m_prev = 0, m_pulse = 0;
  bit           armed = 0, last_rst = 0, flag_in = 0;
  int           pulses = 0;
  int           occ = 0;
  logic [W-1:0] last_out = '0;

  always @(negedge aclk) begin
    if (armed) begin
      occ = exp_q.size();
      if (last_rst) begin
        check("rst_s_tready", W'(s_axis_tready), W'(0));
        check("rst_m_tvalid", W'(m_axis_tvalid), W'(0));
        check("rst_s_tready_w4", W'(s_tready4), W'(0));
      end else begin
        check("s_tready", W'(s_axis_tready), W'(occ < 2));
        check("m_tvalid", W'(m_axis_tvalid), W'(occ != 0));
        check("s_tready_w4", W'(s_tready4), W'(occ < 2));
        check("m_tvalid_w4", W'(m_tvalid4), W'(occ != 0));
      end
      check("tag_pulse", W'(tag_pulse), W'(m_pulse));
      check("tag_position", W'(tag_position), W'(m_pos));
      check("tag_count", W'(tag_count), W'(m_count));
      check("tag_pulse_w4", W'(tag_pulse4), W'(m_pulse));
      check("tag_position_w4", W'(tag_position4), W'(m_pos % 16));
      check("tag_count_w4", W'(tag_count4), W'(m_count % 16));
      if (tag_pulse) pulses++;
      if (m_axis_tvalid && m_axis_tready) begin
        if (occ == 0) check("unexpected_beat", W'(1), W'(0));
        else begin
          check("m_tdata", m_axis_tdata, exp_q[0]);
          check("m_tdata_w4", m_tdata4, exp_q[0]);
          last_out = m_axis_tdata;
          void'(exp_q.pop_front());
        end
      end
    end
    if (areset) begin
      exp_q.delete();
      m_cnt = 0; m_prev = 0; m_pos = 0; m_count = 0; m_pulse = 0;
      last_rst = 1; armed = 1;
    end else begin
      last_rst = 0;
      if (armed) begin
        m_pulse = 0;
        if (s_axis_tvalid && s_axis_tready) begin
          flag_in = s_axis_tdata[TB];
          if (flag_in && !m_prev) begin
            m_pulse = 1;
            m_pos   = m_cnt;
            m_count = m_count + 1;
          end
          m_prev = flag_in;
          m_cnt  = m_cnt + 1;
          exp_q.push_back(exp_out(s_axis_tdata));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  bit rand_ready = 0;
  bit hold_ready = 1;

  task automatic step();
    @(posedge aclk);
    #1;
    m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : hold_ready;
  endtask

  task automatic send(input logic [W-1:0] d);
    bit taken;
    taken = 0;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    for (int n = 0; n < 1000 && !taken; n++) begin
      taken = s_axis_tready;
      step();
    end
    s_axis_tvalid = 1'b0;
    if (!taken) check("send_timeout", W'(0), W'(1));
  endtask

  task automatic do_reset(input int cycles);
    areset = 1'b1;
    repeat (cycles) step();
    areset = 1'b0;
    step();
  endtask

  task automatic drain();
    rand_ready = 0;
    hold_ready = 1;
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) step();
    step();
    check("drain_empty", W'(exp_q.size()), W'(0));
  endtask

  // ---------------- directed + random sequence ----------------
  logic [W-1:0] ones;
  int           ev_before;

  initial begin
    // Power-up reset.
    do_reset(3);
    check("init_position", W'(tag_position), W'(0));
    check("init_count", W'(tag_count), W'(0));

    // Single flagged beat at index 4, downstream always ready.
    pulses = 0;
    for (int i = 0; i < 10; i++) send(rand_data(i == 4));
    drain();
    check("t2_position", W'(tag_position), W'(4));
    check("t2_count", W'(tag_count), W'(1));
    check("t2_pulses", W'(pulses), W'(1));

    // A run of flags (2..4) counts once; index 7 is a second event.
    do_reset(3);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      send(rand_data(i == 2 || i == 3 || i == 4 || i == 7));
      if (i == 5) check("t3_first_position", W'(tag_position), W'(2));
    end
    drain();
    check("t3_position", W'(tag_position), W'(7));
    check("t3_count", W'(tag_count), W'(2));
    check("t3_pulses", W'(pulses), W'(2));

    // Mid-stream reset with both skid slots occupied; held beats are dropped.
    hold_ready = 0;
    m_axis_tready = 1'b0;
    send(rand_data(1));
    send(rand_data(0));
    do_reset(3);
    check("t4_m_tvalid_after_rst", W'(m_axis_tvalid), W'(0));
    check("t4_count_after_rst", W'(tag_count), W'(0));
    hold_ready = 1;
    send(rand_data(1));
    drain();
    check("t4_first_index", W'(tag_position), W'(0));
    check("t4_count", W'(tag_count), W'(1));

    // All-ones beat: flag bit handling per build option.
    ones = '1;
    send(ones);
    drain();
`ifdef AXIS_TAG_EXTRACTOR_STRIP_EN
    ones[TB] = 1'b0;
`endif
    check("t5_all_ones", last_out, ones);

    // Counter wrap on the 4-bit instance: flag at index 16 reports 0.
    do_reset(3);
    for (int i = 0; i < 17; i++) send(rand_data(i == 16));
    drain();
    check("t6_position_w4", W'(tag_position4), W'(0));
    check("t6_count_w4", W'(tag_count4), W'(1));
    check("t6_position", W'(tag_position), W'(16));

    // Random traffic with random downstream backpressure.
    ev_before = pulses;
    rand_ready = 1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) step();
      send(rand_data($urandom_range(0, 9) < 3));
    end
    drain();
    check("t7_pulses_vs_count", W'(pulses - ev_before), W'(m_count - 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
